hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk_i  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset, synchronous, active-high.
REQ-003 idex_memread_i  input  1  MemRead currently held in the ID/EX register.
REQ-004 idex_rt_i  input  5  load destination register held in ID/EX.
REQ-005 ifid_rs_i, ifid_rt_i  input  5 each  source registers of the instruction in IF/ID.
REQ-006 branch_taken_i  input  1  branch resolved taken in ID this cycle.
REQ-007 mem_req_i  input  1  MEM stage issues a data-memory access this cycle.
REQ-008 mem_ack_i  input  1  data memory completes the outstanding access.
REQ-009 pc_write_o  output  1  PC update enable.
REQ-010 ifid_write_o  output  1  IF/ID load enable.
REQ-011 ifid_flush_o  output  1  IF/ID cleared to NOP at next edge.
REQ-012 idex_bubble_o  output  1  ID/EX loads zero control signals at next edge.
REQ-013 pipe_hold_o  output  1  ID/EX, EX/MEM, MEM/WB hold their contents.
REQ-014 stall_cnt_o  output  16  saturating count of cycles with pc_write_o=0.
REQ-015 timeout_o  output  1  sticky memory-timeout flag.

Function
REQ-016 States: RUN, MEM_WAIT; state register 1 bit, outputs decoded from state plus inputs.
REQ-017 Load-use hit = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
REQ-018 RUN, mem_req_i=1, mem_ack_i=0: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1; next state MEM_WAIT.
REQ-019 RUN, mem_req_i=1, mem_ack_i=1 same cycle: zero-wait access, no hold, stay RUN.
REQ-020 MEM_WAIT: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, ifid_flush_o=0, idex_bubble_o=0 until mem_ack_i=1.
REQ-021 MEM_WAIT with mem_ack_i=1: hold released that cycle (all enables per RUN rules using current inputs); next state RUN.
REQ-022 Priority in any cycle: memory hold > branch flush > load-use stall.
REQ-023 Branch flush (not held): ifid_flush_o=1 for exactly that cycle; pc_write_o=1; idex_bubble_o=0.
REQ-024 Load-use stall (not held, no branch): pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for exactly one cycle; next cycle hit clears because bubble sits in ID/EX.
REQ-025 Idle RUN (no event): pc_write_o=1, ifid_write_o=1, other control outputs 0.
REQ-026 stall_cnt_o increments by 1 each cycle pc_write_o=0; saturates at 16'hFFFF, no wrap.
REQ-027 Wait counter (8 bit) counts MEM_WAIT cycles, clears on entry to RUN; reaching 255 sets timeout_o=1, forces state RUN next cycle.
REQ-028 timeout_o stays 1 until reset; block otherwise continues normal operation.

Reset
REQ-029 rst_i=1 at an edge: state=RUN, stall_cnt_o=0, wait counter=0, timeout_o=0; overrides all other events including a pending MEM_WAIT.
REQ-030 While rst_i=1: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, pipe_hold_o=0.

Structure
REQ-031 State encoding, WAIT_LIMIT=255 and STALL_CNT_W=16 reside in the shared CPU package.
REQ-032 Load-use comparator is one combinational sub-module, load_use_detect; FSM and counters remain in hazard_ctrl.

Verification
REQ-033 idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 -> one cycle pc_write_o=0, idex_bubble_o=1; stall_cnt_o 0->1.
REQ-034 Same with idex_rt_i=0 -> no stall; pc_write_o=1 throughout.
REQ-035 mem_req_i=1, mem_ack_i after 3 cycles -> pipe_hold_o=1 for 3 cycles, released on ack cycle; stall_cnt_o=3.
REQ-036 branch_taken_i=1 and load-use hit together -> ifid_flush_o=1, idex_bubble_o=0; branch during MEM_WAIT -> flush only on ack cycle.
REQ-037 mem_req_i=1, no ack for 255 cycles -> timeout_o=1, state RUN next cycle; rst_i clears timeout_o and stall_cnt_o to 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU pipeline definitions for the hazard controller: FSM encoding,
// memory-wait limit and stall counter width.
package hazard_ctrl_pkg;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   localparam logic [7:0] WAIT_LIMIT  = 8'd255;
   localparam int         STALL_CNT_W = 16;

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (v == '1) ? v : v + STALL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator: the load in ID/EX writes a register that the
// instruction in IF/ID reads. r0 never creates a dependency.
module load_use_detect (
   input  logic       idex_memread_i,
   input  logic [4:0] idex_rt_i,
   input  logic [4:0] ifid_rs_i,
   input  logic [4:0] ifid_rt_i,
   output logic       hit_o
);

   assign hit_o = idex_memread_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait hold, branch flush, load-use stall,
// stall-cycle counter and sticky memory-timeout flag.
//
//   state       | meaning
//   ST_RUN      | normal issue; events resolved by priority hold > flush > stall
//   ST_MEM_WAIT | data access outstanding; pipeline held until ack or timeout
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   idex_memread_i,
   input  logic [4:0]             idex_rt_i,
   input  logic [4:0]             ifid_rs_i,
   input  logic [4:0]             ifid_rt_i,
   input  logic                   branch_taken_i,
   input  logic                   mem_req_i,
   input  logic                   mem_ack_i,
   output logic                   pc_write_o,
   output logic                   ifid_write_o,
   output logic                   ifid_flush_o,
   output logic                   idex_bubble_o,
   output logic                   pipe_hold_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o,
   output logic                   timeout_o
);

   state_e                 state_q, state_d;
   logic [7:0]             wait_cnt_q, wait_cnt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   timeout_q, timeout_d;
   logic                   load_use_hit;
   logic                   mem_hold;

   load_use_detect u_load_use_detect (
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .hit_o          (load_use_hit)
   );

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_d     = timeout_q;
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_hold_o   = 1'b0;

      // An acked access releases the hold in the same cycle, in either state.
      mem_hold = (state_q == ST_MEM_WAIT) ? !mem_ack_i : (mem_req_i && !mem_ack_i);

      // Wait timer is a down-counter loaded on MEM_WAIT entry; terminal count 0
      // marks the final permitted wait cycle.
      case (state_q)
         ST_RUN: begin
            wait_cnt_d = 8'd0;
            if (mem_req_i && !mem_ack_i) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_LIMIT - 8'd1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ack_i) begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == 8'd0) begin
               state_d    = ST_RUN;
               timeout_d  = 1'b1;
               wait_cnt_d = 8'd0;
            end else begin
               wait_cnt_d = wait_cnt_q - 8'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (rst_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
      end else if (mem_hold) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         pipe_hold_o   = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o  = 1'b1;
      end else if (load_use_hit) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end

      stall_cnt_d = pc_write_o ? stall_cnt_q : sat_inc(stall_cnt_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= 8'd0;
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner cases
// and randomized traffic against a behavioural reference model.
module tb_hazard_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        idex_memread_i = 1'b0;
   logic [4:0]  idex_rt_i = '0, ifid_rs_i = '0, ifid_rt_i = '0;
   logic        branch_taken_i = 1'b0, mem_req_i = 1'b0, mem_ack_i = 1'b0;
   logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o;
   logic [15:0] stall_cnt_o;
   logic        timeout_o;

   hazard_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ack_i      (mem_ack_i),
      .pc_write_o     (pc_write_o),
      .ifid_write_o   (ifid_write_o),
      .ifid_flush_o   (ifid_flush_o),
      .idex_bubble_o  (idex_bubble_o),
      .pipe_hold_o    (pipe_hold_o),
      .stall_cnt_o    (stall_cnt_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference model: "waiting" flag, number of wait cycles seen so far,
   // stall cycles (saturating) and the sticky timeout.
   bit  m_waiting = 0;
   int  m_waited  = 0;
   int  m_stalls  = 0;
   bit  m_to      = 0;
   logic [4:0] last_exp;

   typedef struct {
      logic       rst, mr;
      logic [4:0] xrt, rs, rt;
      logic       br, req, ack;
      logic [4:0] exp_ctl;   // {pc_write, ifid_write, flush, bubble, hold}
   } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] model_ctl(input logic rst, mr, input logic [4:0] xrt, rs, rt,
                                            input logic br, req, ack);
      bit hit, held;
      if (rst) return 5'b00110;
      hit  = mr && (xrt != 0) && (xrt == rs || xrt == rt);
      held = m_waiting ? !ack : (req && !ack);
      if (held) return 5'b00001;
      if (br)   return 5'b11100;
      if (hit)  return 5'b00010;
      return 5'b11000;
   endfunction

   function automatic void model_edge(input logic rst, input logic req, ack, input logic pc_wr);
      if (rst) begin
         m_waiting = 0; m_waited = 0; m_stalls = 0; m_to = 0;
         return;
      end
      if (!pc_wr && m_stalls < 65535) m_stalls++;
      if (!m_waiting) begin
         if (req && !ack) begin m_waiting = 1; m_waited = 0; end
      end else if (ack) begin
         m_waiting = 0;
      end else begin
         m_waited++;
         if (m_waited >= 255) begin m_to = 1; m_waiting = 0; end
      end
   endfunction

   task automatic step(input logic rst, mr, input logic [4:0] xrt, rs, rt,
                       input logic br, req, ack);
      @(negedge clk_i);
      rst_i = rst; idex_memread_i = mr; idex_rt_i = xrt; ifid_rs_i = rs; ifid_rt_i = rt;
      branch_taken_i = br; mem_req_i = req; mem_ack_i = ack;
      #1;
      last_exp = model_ctl(rst, mr, xrt, rs, rt, br, req, ack);
      check("ctl", {11'd0, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o},
            {11'd0, last_exp});
      check("stall_cnt", stall_cnt_o, 16'(m_stalls));
      check("timeout", {15'd0, timeout_o}, {15'd0, m_to});
      model_edge(rst, req, ack, last_exp[4]);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      vecs[0]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'b11000};
      vecs[1]  = '{0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 5'b00010};
      vecs[2]  = '{0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 5'b00010};
      vecs[3]  = '{0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'b11000};
      vecs[4]  = '{0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 5'b11000};
      vecs[5]  = '{0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 5'b11100};
      vecs[6]  = '{0, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 5'b11100};
      vecs[7]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 5'b11000};
      vecs[8]  = '{0, 1, 5'd3, 5'd3, 5'd3, 0, 1, 1, 5'b00010};
      vecs[9]  = '{1, 1, 5'd3, 5'd3, 5'd3, 1, 1, 0, 5'b00110};
      vecs[10] = '{0, 1, 5'd3, 5'd4, 5'd6, 0, 0, 0, 5'b11000};
      vecs[11] = '{0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 5'b11100};

      repeat (2) @(posedge clk_i);
      do_reset();

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rst, vecs[i].mr, vecs[i].xrt, vecs[i].rs, vecs[i].rt,
              vecs[i].br, vecs[i].req, vecs[i].ack);
         check($sformatf("vec%0d", i),
               {11'd0, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o},
               {11'd0, vecs[i].exp_ctl});
      end

      // Load-use on rs: one stall cycle, bubble then clears the hit.
      do_reset();
      step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
      check("lu_pc_write", {15'd0, pc_write_o}, 16'd0);
      check("lu_bubble", {15'd0, idex_bubble_o}, 16'd1);
      idle();
      check("lu_stall_cnt", stall_cnt_o, 16'd1);

      // Same dependency through r0: no stall.
      do_reset();
      step(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      check("r0_pc_write", {15'd0, pc_write_o}, 16'd1);
      idle();
      check("r0_stall_cnt", stall_cnt_o, 16'd0);

      // Memory access acked on the fourth cycle: three held cycles.
      do_reset();
      repeat (3) begin
         step(0, 0, 0, 0, 0, 0, 1, 0);
         check("mem_hold", {15'd0, pipe_hold_o}, 16'd1);
      end
      step(0, 0, 0, 0, 0, 0, 1, 1);
      check("mem_release", {15'd0, pipe_hold_o}, 16'd0);
      idle();
      check("mem_stall_cnt", stall_cnt_o, 16'd3);

      // Branch beats load-use; branch during wait flushes only on ack.
      do_reset();
      step(0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0);
      check("br_lu_flush", {15'd0, ifid_flush_o}, 16'd1);
      check("br_lu_bubble", {15'd0, idex_bubble_o}, 16'd0);
      step(0, 0, 0, 0, 0, 1, 1, 0);
      check("br_wait_flush0", {15'd0, ifid_flush_o}, 16'd0);
      step(0, 0, 0, 0, 0, 1, 1, 0);
      check("br_wait_flush1", {15'd0, ifid_flush_o}, 16'd0);
      step(0, 0, 0, 0, 0, 1, 1, 1);
      check("br_ack_flush", {15'd0, ifid_flush_o}, 16'd1);

      // Timeout after 255 unacked wait cycles, then reset clears it.
      do_reset();
      step(0, 0, 0, 0, 0, 0, 1, 0);
      repeat (255) step(0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      check("to_flag", {15'd0, timeout_o}, 16'd1);
      check("to_run_hold", {15'd0, pipe_hold_o}, 16'd0);
      check("to_run_pc", {15'd0, pc_write_o}, 16'd1);
      idle();
      check("to_sticky", {15'd0, timeout_o}, 16'd1);
      do_reset();
      idle();
      check("rst_timeout", {15'd0, timeout_o}, 16'd0);
      check("rst_stall_cnt", stall_cnt_o, 16'd0);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         step(($urandom % 64) == 0, $urandom % 2,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              ($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0);
      end

      // Stall counter saturation: continuous load-use hit.
      do_reset();
      @(negedge clk_i);
      rst_i = 0; idex_memread_i = 1; idex_rt_i = 5'd5; ifid_rs_i = 5'd5; ifid_rt_i = 5'd0;
      branch_taken_i = 0; mem_req_i = 0; mem_ack_i = 0;
      repeat (65534) @(posedge clk_i);
      m_stalls = 65534;
      step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
      check("sat_pre", stall_cnt_o, 16'hFFFE);
      step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
      check("sat_max", stall_cnt_o, 16'hFFFF);
      step(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
      check("sat_nowrap", stall_cnt_o, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
